// File: rtl/imm_halfword_packer_pkg.sv
// imm_halfword_packer shared types.
// States, widths and the beat record.
package imm_pack_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  typedef struct packed {
    logic [HALF_W-1:0] half;
    logic              zext;
    logic              last;
  } beat_t;

  // Beat presented on the output for a given state and held word.
  function automatic beat_t beat_of(
    input state_t            s,
    input logic [WORD_W-1:0] w
  );
    beat_t b;
    b = '0;
    unique case (1'b1)
      (s == SHORT): begin
        b.half = w[HALF_W-1:0];
        b.zext = 1'b1;
        b.last = 1'b1;
      end
      (s == HIGH): begin
        b.half = w[WORD_W-1:HALF_W];
        b.zext = 1'b0;
        b.last = 1'b0;
      end
      (s == LOW): begin
        b.half = w[HALF_W-1:0];
        b.zext = 1'b0;
        b.last = 1'b1;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imm_halfword_packer_if.sv
// imm_halfword_packer word-in / halfword-out bus.
// master drives words and sink ready; slave is the packer.
interface imm_halfword_packer_if;
  import imm_pack_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [HALF_W-1:0] out_half;
  logic              out_zext;
  logic              out_last;

  modport master (
    output in_valid,
    output in_word,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_half,
    input  out_zext,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_word,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_half,
    output out_zext,
    output out_last
  );

endinterface

// File: rtl/imm_halfword_packer_wrap_counter.sv
// Free-running wrap-around event counter.
// Synchronous reset, single increment enable.
module wrap_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count enabled events modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imm_halfword_packer.sv
// imm_halfword_packer: 32-bit word to 16-bit beats.
// Upper-zero words go out as one zext beat.
module imm_halfword_packer
  import imm_pack_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit EN_COMPRESS = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  imm_halfword_packer_if.slave bus,
  output logic [CNT_W-1:0]   cnt_short,
  output logic [CNT_W-1:0]   cnt_long
);

  state_t            state_q;
  state_t            state_d;
  state_t            entry;
  logic [WORD_W-1:0] hold_q;
  logic [WORD_W-1:0] hold_d;
  logic              in_fire;
  logic              out_fire;
  logic              can_end;
  logic              upper_zero;
  beat_t             beat;

  assign upper_zero = (bus.in_word[WORD_W-1:HALF_W] == '0);
  assign entry = (EN_COMPRESS && upper_zero) ? SHORT : HIGH;

  // Final beat of a word: the slot frees as it leaves.
  assign can_end = (state_q == SHORT) || (state_q == LOW);

  // Held off during reset so no word slips into a clearing block.
  assign bus.in_ready = !reset
                     && ((state_q == IDLE)
                      || (can_end && bus.out_ready));

  assign bus.out_valid = (state_q != IDLE);

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  assign beat         = beat_of(state_q, hold_q);
  assign bus.out_half = beat.half;
  assign bus.out_zext = beat.zext;
  assign bus.out_last = beat.last;

  // Next state and hold contents.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (in_fire) begin
      hold_d = bus.in_word;
    end
    unique case (state_q)
      IDLE: begin
        if (in_fire) state_d = entry;
      end
      HIGH: begin
        if (out_fire) state_d = LOW;
      end
      SHORT, LOW: begin
        if (out_fire) begin
          state_d = in_fire ? entry : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and held word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  wrap_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_short (
    .clk   (clk),
    .reset (reset),
    .en    (out_fire && (state_q == SHORT)),
    .count (cnt_short)
  );

  wrap_counter #(
    .CNT_W (CNT_W)
  ) u_cnt_long (
    .clk   (clk),
    .reset (reset),
    .en    (out_fire && (state_q == LOW)),
    .count (cnt_long)
  );

endmodule

// File: doc/imm_halfword_packer.md
# imm_halfword_packer

Sequential narrowing encoder for the datapath's constant path: the inverse of zero-extension. Accepts 32-bit words over a valid/ready handshake and emits 16-bit halfword beats. A word whose upper half is zero is sent as one beat, flagged as a zero-extended immediate. Any other word is sent as two beats, upper half first. Sits between the register/constant source and the 16-bit immediate channel; the existing zero-extender on the far side reconstructs flagged beats.

## Interface
- `CNT_W`, default 16: width of the statistics counters.
- `EN_COMPRESS`, default 1: when 1, upper-zero words use the single-beat form; when 0, every word is sent as two beats.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_word` is valid.
- `in_ready`  out  1  block can take a word this cycle.
- `in_word`  in  32  word to encode.
- `out_valid`  out  1  `out_half` is valid.
- `out_ready`  in  1  sink accepts the current beat.
- `out_half`  out  16  halfword payload.
- `out_zext`  out  1  1 = the beat is a complete word; the receiver zero-extends it.
- `out_last`  out  1  final beat of the current word.
- `cnt_short`  out  `CNT_W`  count of words sent as one beat; wraps.
- `cnt_long`  out  `CNT_W`  count of words sent as two beats; wraps.

## Operation
- Input transfer: `in_valid && in_ready`. Output transfer: `out_valid && out_ready`.
- States:
  - IDLE: no word held.
  - SHORT: single beat pending.
  - HIGH: upper beat pending.
  - LOW: lower beat pending.
- On an input transfer, the word is latched into a 32-bit holding register.
  - If `EN_COMPRESS==1` and `in_word[31:16]==0`, go to SHORT.
  - Otherwise go to HIGH.
- Beats by state:
  - SHORT: `out_half=hold[15:0]`, `out_zext=1`, `out_last=1`.
  - HIGH: `out_half=hold[31:16]`, `out_zext=0`, `out_last=0`.
  - LOW: `out_half=hold[15:0]`, `out_zext=0`, `out_last=1`.
- Transitions:
  - HIGH→LOW on an output transfer.
  - SHORT or LOW, on an output transfer: to SHORT/HIGH if an input transfer occurs in the same cycle, else to IDLE.
- `in_ready = (state==IDLE) || ((state==SHORT || state==LOW) && out_ready)`. Never asserted in HIGH.
  - This is the only combinational input→output path. No path from `in_valid` to `out_valid`.
- `out_valid = (state != IDLE)`, registered.
  - While a beat is stalled (`out_valid && !out_ready`), `out_half`, `out_zext` and `out_last` hold stable.
- Counters:
  - `cnt_short` increments on the output transfer of a SHORT beat.
  - `cnt_long` increments on the output transfer of a LOW beat.
  - Modulo 2^`CNT_W`.
- Value 0x00000000 counts as upper-zero: one beat of 0x0000.

## Timing
- Reset, checked on the first edge with `reset=1`:
  - state goes to IDLE.
  - `out_valid=0`, `out_half=0`, `out_zext=0`, `out_last=0`.
  - `cnt_short=0`, `cnt_long=0`.
  - `in_ready=0` while `reset` is high; `in_ready=1` in the first cycle after reset is released.
- Reset mid-word, in any state: the held word is discarded with no further beats, and the counters clear.
- Latency: a word accepted at edge t shows its first beat with `out_valid=1` in the cycle after t.
- Throughput with `out_ready` held at 1:
  - back-to-back short words: 1 word/cycle.
  - long words: 1 word per 2 cycles.
- Simultaneous accept of the next word and send of the last beat: both happen on the same edge, with no bubble.
- `out_ready` low: state, payload and counters hold indefinitely.

## Structure
- Shared package `imm_pack_pkg` contains:
  - `state_t`: IDLE, SHORT, HIGH, LOW, 2-bit encoding.
  - constants `HALF_W=16` and `WORD_W=32`.
  - the beat record typedef: half, zext, last.
- One natural sub-module: `wrap_counter`, parameterised by `CNT_W`, with synchronous reset and an increment enable. It is instantiated twice, for `cnt_short` and `cnt_long`.
- Everything else stays in a single always block for the state and hold register, plus continuous assigns for `in_ready` and the beat fields.

## Test plan
- `in_word`=0x00007066, `out_ready`=1 → one beat 0x7066, `zext=1`, `last=1`, first cycle after accept; `cnt_short`=1.
- `in_word`=0x0001FFEF → beats 0x0001 (`zext=0`, `last=0`) then 0xFFEF (`last=1`) on consecutive cycles; `cnt_long`=1; `in_ready`=0 during the 0x0001 beat.
- Back-to-back 0x00000000, 0x0000FFEF, 0x70660000 with `in_valid`=1 and `out_ready`=1 → beats 0x0000, 0xFFEF, 0x7066, 0x0000 on four consecutive cycles; counters end at short=2, long=1.
- `EN_COMPRESS`=0, `in_word`=0x00001234 → two beats 0x0000 then 0x1234, both with `zext=0`.
- `out_ready`=0 for 5 cycles during the HIGH beat of 0xABCD5678 → 0xABCD held stable; then 0x5678 follows; no beat lost or duplicated.
- `reset` asserted during the LOW beat of 0xDEAD0001 → next cycle `out_valid`=0 and counters=0; word 0x00000042 after release → single beat 0x0042.
